// File: rtl/imem_stream_loader.sv
// Byte-stream instruction-memory loader: a 16-bit word count header followed by
// big-endian 32-bit words, each written as a one-cycle strobe at BASE_ADDR + k.
module imem_stream_loader #(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              init_mode,
  output logic              write_enable,
  output logic [ADDR_W-1:0] init_address,
  output logic [31:0]       init_instruction,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int KW = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [7:0]      r_hdr_hi;
  logic [15:0]     r_n;
  logic [KW-1:0]   r_k;
  logic [1:0]      r_bcnt;
  logic [31:0]     r_shift;
  logic            r_done;
  logic            r_error;

  logic            w_accept;
  logic [15:0]     w_hdr_n;
  logic            w_n_bad;
  logic [KW-1:0]   w_k_inc;
  logic            w_more;
  logic            w_set_done;
  logic            w_set_error;
  logic            w_clr_status;

  assign w_hdr_n  = {r_hdr_hi, in_data};
  assign w_n_bad  = (w_hdr_n == 16'd0) || (32'(w_hdr_n) > (32'd1 << ADDR_W));
  assign w_k_inc  = r_k + KW'(1);
  assign w_more   = 32'(w_k_inc) < 32'(r_n);
  // abort wins over a byte presented in the same cycle
  assign w_accept = in_ready & in_valid & ~abort;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and status-update decode
  always_comb begin
    w_next_state = r_state;
    w_set_done   = 1'b0;
    w_set_error  = 1'b0;
    w_clr_status = 1'b0;
    if ((r_state != IDLE) && abort) begin
      w_next_state = IDLE;
      w_set_error  = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_next_state = HDR_HI;
            w_clr_status = 1'b1;
          end else begin
            w_next_state = IDLE;
          end
        end
        HDR_HI: begin
          if (in_valid) begin
            w_next_state = HDR_LO;
          end else begin
            w_next_state = HDR_HI;
          end
        end
        HDR_LO: begin
          if (in_valid && w_n_bad) begin
            w_next_state = IDLE;
            w_set_error  = 1'b1;
          end else if (in_valid) begin
            w_next_state = DATA;
          end else begin
            w_next_state = HDR_LO;
          end
        end
        DATA: begin
          if (in_valid && (r_bcnt == 2'd3)) begin
            w_next_state = WRITE;
          end else begin
            w_next_state = DATA;
          end
        end
        WRITE: begin
          if (w_more) begin
            w_next_state = DATA;
          end else begin
            w_next_state = FINISH;
          end
        end
        FINISH: begin
          w_next_state = IDLE;
          w_set_done   = 1'b1;
        end
        default: begin
          w_next_state = IDLE;
        end
      endcase
    end
  end

  // Header capture, word assembly, word index and sticky status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hdr_hi <= 8'd0;
      r_n      <= 16'd0;
      r_k      <= {KW{1'b0}};
      r_bcnt   <= 2'd0;
      r_shift  <= 32'd0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      if (w_clr_status) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end else if (w_set_done) begin
        r_done  <= 1'b1;
        r_error <= 1'b0;
      end else if (w_set_error) begin
        r_done  <= 1'b0;
        r_error <= 1'b1;
      end
      if (w_accept) begin
        case (r_state)
          HDR_HI: r_hdr_hi <= in_data;
          HDR_LO: begin
            r_n    <= w_hdr_n;
            r_k    <= {KW{1'b0}};
            r_bcnt <= 2'd0;
          end
          DATA: begin
            r_shift <= {r_shift[23:0], in_data};
            r_bcnt  <= r_bcnt + 2'd1;
          end
          default: begin
          end
        endcase
      end
      if ((r_state == WRITE) && !abort) begin
        r_k <= w_k_inc;
      end
    end
  end

  assign in_ready         = (r_state == HDR_HI) || (r_state == HDR_LO) || (r_state == DATA);
  assign busy             = (r_state != IDLE);
  assign init_mode        = (r_state != IDLE);
  assign write_enable     = (r_state == WRITE);
  // address wraps modulo 2^ADDR_W by truncation of the sum
  assign init_address     = write_enable ? (ADDR_W'(BASE_ADDR) + r_k[ADDR_W-1:0]) : {ADDR_W{1'b0}};
  assign init_instruction = write_enable ? r_shift : 32'd0;
  assign done             = r_done;
  assign error            = r_error;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Table-driven bench for imem_stream_loader; two instances (BASE_ADDR 0 and 4094)
// share the stimulus and each has its own write scoreboard.
module tb_imem_stream_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;

  logic        rdy0, im0, we0, busy0, done0, err0;
  logic [11:0] addr0;
  logic [31:0] ins0;
  logic        rdy1, im1, we1, busy1, done1, err1;
  logic [11:0] addr1;
  logic [31:0] ins1;

  int checks = 0;
  int failures = 0;
  int wr0 = 0;
  int wr1 = 0;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  typedef struct {
    logic [15:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    bit          gap;
    bit          exp_done;
    bit          exp_err;
    int          exp_writes;
  } vec_t;

  vec_t tbl[6];

  imem_stream_loader #(.ADDR_W(12), .BASE_ADDR(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
    .init_mode(im0), .write_enable(we0), .init_address(addr0),
    .init_instruction(ins0), .busy(busy0), .done(done0), .error(err0)
  );

  imem_stream_loader #(.ADDR_W(12), .BASE_ADDR(4094)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
    .init_mode(im1), .write_enable(we1), .init_address(addr1),
    .init_instruction(ins1), .busy(busy1), .done(done1), .error(err1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Write monitors: every strobe must match the head of its scoreboard
  always @(negedge clk) begin
    if (we0) begin
      wr0++;
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr0_unexpected: write addr=0x%03h data=0x%08h, none expected", addr0, ins0);
      end else begin
        e0 = q0.pop_front();
        chk("wr0_addr", 32'(addr0), 32'(e0.addr));
        chk("wr0_data", ins0, e0.data);
      end
      chk("wr0_init_mode", 32'(im0), 32'd1);
    end
    if (we1) begin
      wr1++;
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr1_unexpected: write addr=0x%03h data=0x%08h, none expected", addr1, ins1);
      end else begin
        e1 = q1.pop_front();
        chk("wr1_addr", 32'(addr1), 32'(e1.addr));
        chk("wr1_data", ins1, e1.data);
      end
      chk("wr1_init_mode", 32'(im1), 32'd1);
    end
  end

  function automatic logic [31:0] word_of(input vec_t v, input int k);
    case (k)
      0:       word_of = v.w0;
      1:       word_of = v.w1;
      2:       word_of = v.w2;
      default: word_of = (32'(k) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endcase
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl0"}, 32'({rdy0, im0, we0, busy0, done0, err0}), 32'd0);
    chk({tag, "_addr0"}, 32'(addr0), 32'd0);
    chk({tag, "_ins0"}, ins0, 32'd0);
    chk({tag, "_ctl1"}, 32'({rdy1, im1, we1, busy1, done1, err1}), 32'd0);
    chk({tag, "_addr1"}, 32'(addr1), 32'd0);
    chk({tag, "_ins1"}, ins1, 32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    while (!rdy0 && t < 20) begin
      in_valid = 1'b0;
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", 32'(rdy0), 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic send_word(input int k, input logic [31:0] w, input bit gap);
    exp_t e;
    e.addr = 12'(k);
    e.data = w;
    q0.push_back(e);
    e.addr = 12'(4094 + k);
    q1.push_back(e);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy0), 32'd1);
    chk({tag, "_mode_after_start"}, 32'(im0), 32'd1);
    chk({tag, "_status_cleared"}, 32'({done0, err0}), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_idle_reached"}, 32'(busy0), 32'd0);
    if (busy0) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic run_session(input vec_t v, input int id);
    int    b0 = wr0;
    int    b1 = wr1;
    string tag = $sformatf("s%0d", id);
    pulse_start(tag);
    send_byte(v.n[15:8], v.gap);
    send_byte(v.n[7:0], v.gap);
    if (!v.exp_err) begin
      for (int k = 0; k < int'(v.n); k++) send_word(k, word_of(v, k), v.gap);
    end
    wait_idle(tag);
    chk({tag, "_done"}, 32'(done0), 32'(v.exp_done));
    chk({tag, "_error"}, 32'(err0), 32'(v.exp_err));
    chk({tag, "_init_mode_low"}, 32'(im0), 32'd0);
    chk({tag, "_writes0"}, 32'(wr0 - b0), 32'(v.exp_writes));
    chk({tag, "_writes1"}, 32'(wr1 - b1), 32'(v.exp_writes));
    chk({tag, "_done1"}, 32'({done1, err1}), 32'({v.exp_done, v.exp_err}));
    chk({tag, "_q_empty"}, 32'(q0.size() + q1.size()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    tbl[0] = '{16'd2,    32'h20080005, 32'h01095020, 32'h00000000, 1'b0, 1'b1, 1'b0, 2};
    tbl[1] = '{16'd0,    32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 0};
    tbl[2] = '{16'd1,    32'hA5C30F96, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 1};
    tbl[3] = '{16'd3,    32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 3};
    tbl[4] = '{16'd4097, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 0};
    tbl[5] = '{16'd4096, 32'h00000001, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 4096};

    #3;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", 32'(busy0), 32'd0);

    for (int i = 0; i < 5; i++) run_session(tbl[i], i);

    // abort together with the last byte of the second word
    b0 = wr0;
    pulse_start("abort");
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_word(0, 32'h13579BDF, 1'b0);
    send_byte(8'h24, 1'b0);
    send_byte(8'h68, 1'b0);
    send_byte(8'hAC, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hE0;
    abort    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    abort    = 1'b0;
    chk("abort_init_mode", 32'(im0), 32'd0);
    chk("abort_status", 32'({busy0, done0, err0, rdy0}), 32'b0010);
    repeat (4) @(negedge clk);
    chk("abort_writes", 32'(wr0 - b0), 32'd1);
    chk("abort_q_empty", 32'(q0.size() + q1.size()), 32'd0);

    // reset mid-DATA
    b0 = wr0;
    pulse_start("rst");
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_word(0, 32'h0BADF00D, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("rst_mid");
    chk("rst_writes", 32'(wr0 - b0), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_idle", 32'({busy0, done0, err0}), 32'd0);
    chk("rst_q_empty", 32'(q0.size() + q1.size()), 32'd0);
    run_session(tbl[0], 10);

    run_session(tbl[5], 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
